// File: rtl/trap_controller_if.sv
// Trap/CSR interface between the hazard/execute side (master) and the trap controller (slave).
interface trap_controller_if #(
  parameter int XLEN = 32
);
  logic            trapRequest;
  logic [3:0]      trapCause;
  logic [XLEN-1:0] trapPc;
  logic [XLEN-1:0] trapValue;
  logic            mretValid;
  logic            csrValid;
  logic [1:0]      csrOp;
  logic [11:0]     csrAddress;
  logic [XLEN-1:0] csrWriteData;
  logic [XLEN-1:0] csrReadData;
  logic            csrIllegal;
  logic            redirectValid;
  logic [XLEN-1:0] redirectTarget;
  logic            trapStall;

  modport master (
    output trapRequest, trapCause, trapPc, trapValue, mretValid,
           csrValid, csrOp, csrAddress, csrWriteData,
    input  csrReadData, csrIllegal, redirectValid, redirectTarget, trapStall
  );

  modport slave (
    input  trapRequest, trapCause, trapPc, trapValue, mretValid,
           csrValid, csrOp, csrAddress, csrWriteData,
    output csrReadData, csrIllegal, redirectValid, redirectTarget, trapStall
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap responder: commits trap state, redirects fetch to mtvec/mepc,
// stalls the pipeline while the redirect drains, and hosts the M-mode CSR file.
module trap_controller #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              DRAIN_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  trap_controller_if.slave  bus
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] target_q;
  logic            redirect_valid_q;
  logic            trap_stall_q;

  logic            mie_q;
  logic            mpie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [3:0]      mcause_q;
  logic [XLEN-1:0] mtval_q;

  logic [XLEN-1:0] csr_rdata_d;
  logic            csr_legal_d;
  logic [XLEN-1:0] csr_wdata_d;
  logic            csr_we_d;

  // CSR read mux; reflects the state before any write at the coming edge.
  always_comb begin
    csr_rdata_d = '0;
    csr_legal_d = 1'b1;
    case (bus.csrAddress)
      12'h300: begin
        csr_rdata_d[3] = mie_q;
        csr_rdata_d[7] = mpie_q;
      end
      12'h305: csr_rdata_d = mtvec_q;
      12'h340: csr_rdata_d = mscratch_q;
      12'h341: csr_rdata_d = mepc_q;
      12'h342: csr_rdata_d = {{(XLEN-4){1'b0}}, mcause_q};
      12'h343: csr_rdata_d = mtval_q;
      default: csr_legal_d = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.csrOp)
      2'b01:   csr_wdata_d = bus.csrWriteData;
      2'b10:   csr_wdata_d = csr_rdata_d | bus.csrWriteData;
      2'b11:   csr_wdata_d = csr_rdata_d & ~bus.csrWriteData;
      default: csr_wdata_d = csr_rdata_d;
    endcase
  end

  // Trap and MRET take priority over a CSR write; RS/RC with a zero mask never writes.
  assign csr_we_d = (state_q == IDLE) && !bus.trapRequest && !bus.mretValid &&
                    bus.csrValid && csr_legal_d && (bus.csrOp != 2'b00) &&
                    !(bus.csrOp[1] && (bus.csrWriteData == '0));

  assign bus.csrReadData    = csr_rdata_d;
  assign bus.csrIllegal     = bus.csrValid && !csr_legal_d;
  assign bus.redirectValid  = redirect_valid_q;
  assign bus.redirectTarget = target_q;
  assign bus.trapStall      = trap_stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      target_q         <= '0;
      redirect_valid_q <= 1'b0;
      trap_stall_q     <= 1'b0;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mtvec_q          <= RESET_VECTOR;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.trapRequest) begin
            mepc_q           <= {bus.trapPc[XLEN-1:2], 2'b00};
            mcause_q         <= bus.trapCause;
            mtval_q          <= bus.trapValue;
            mpie_q           <= mie_q;
            mie_q            <= 1'b0;
            target_q         <= mtvec_q;
            redirect_valid_q <= 1'b1;
            trap_stall_q     <= 1'b1;
            state_q          <= REDIRECT;
          end else if (bus.mretValid) begin
            mie_q            <= mpie_q;
            mpie_q           <= 1'b1;
            target_q         <= mepc_q;
            redirect_valid_q <= 1'b1;
            trap_stall_q     <= 1'b1;
            state_q          <= REDIRECT;
          end else if (csr_we_d) begin
            case (bus.csrAddress)
              12'h300: begin
                mie_q  <= csr_wdata_d[3];
                mpie_q <= csr_wdata_d[7];
              end
              12'h305: mtvec_q    <= {csr_wdata_d[XLEN-1:2], 2'b00};
              12'h340: mscratch_q <= csr_wdata_d;
              12'h341: mepc_q     <= {csr_wdata_d[XLEN-1:2], 2'b00};
              12'h342: mcause_q   <= csr_wdata_d[3:0];
              12'h343: mtval_q    <= csr_wdata_d;
              default: ;
            endcase
          end
        end
        REDIRECT: begin
          redirect_valid_q <= 1'b0;
          cnt_q            <= DRAIN_INIT;
          state_q          <= DRAIN;
        end
        DRAIN: begin
          if (cnt_q <= 4'd1) begin
            trap_stall_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: redirect targets go through a scoreboard queue,
// CSR state and stall timing are checked directly.
module tb_trap_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sb_q[$];

  trap_controller_if #(.XLEN(32)) bus ();

  trap_controller #(.XLEN(32), .RESET_VECTOR(32'h0), .DRAIN_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Scoreboard consumer: every redirect strobe must match the oldest pushed target.
  always @(negedge clock) begin
    if (!reset && bus.redirectValid) begin
      if (sb_q.size() == 0) check("redir_unexpected", 32'd1, 32'd0);
      else check("redir_target", bus.redirectTarget, sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.trapRequest  = 1'b0;
    bus.trapCause    = '0;
    bus.trapPc       = '0;
    bus.trapValue    = '0;
    bus.mretValid    = 1'b0;
    bus.csrValid     = 1'b0;
    bus.csrOp        = 2'b00;
    bus.csrAddress   = '0;
    bus.csrWriteData = '0;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csrAddress = a;
    #1;
    check(tag, bus.csrReadData, exp);
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input logic exp_illegal);
    bus.csrValid = 1'b1;
    bus.csrOp = op;
    bus.csrAddress = a;
    bus.csrWriteData = wd;
    #1;
    check("csr_illegal", {31'd0, bus.csrIllegal}, {31'd0, exp_illegal});
    tick();
    idle_inputs();
  endtask

  task automatic wait_drain(input int exp_len, input bit retrig, input logic [31:0] pc);
    int n = 0;
    for (int i = 0; i < 20 && bus.trapStall; i++) begin
      n++;
      if (retrig) begin
        bus.trapRequest = 1'b1;
        bus.trapPc = pc + 32'h40;
      end
      tick();
      bus.trapRequest = 1'b0;
    end
    check("stall_len", n, exp_len);
  endtask

  task automatic trap_seq(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] val,
                          input logic [31:0] exp_tgt, input bit with_csr, input bit retrig);
    bus.trapRequest = 1'b1;
    bus.trapCause = c;
    bus.trapPc = pc;
    bus.trapValue = val;
    if (with_csr) begin
      bus.csrValid = 1'b1;
      bus.csrOp = 2'b01;
      bus.csrAddress = 12'h340;
      bus.csrWriteData = 32'd5;
    end
    sb_q.push_back(exp_tgt);
    tick();
    idle_inputs();
    check("trap_latency", {31'd0, bus.redirectValid}, 32'd1);
    wait_drain(3, retrig, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_redirect", {31'd0, bus.redirectValid}, 32'd0);
    check("rst_stall", {31'd0, bus.trapStall}, 32'd0);
    check("rst_target", bus.redirectTarget, 32'd0);
    chk_csr("rst_mtvec", 12'h305, 32'h0);
    chk_csr("rst_mstatus", 12'h300, 32'h0);

    // First trap out of reset goes to the reset vector.
    trap_seq(4'd2, 32'h100, 32'hDEAD, 32'h0, 1'b0, 1'b0);
    chk_csr("mepc", 12'h341, 32'h100);
    chk_csr("mcause", 12'h342, 32'h2);
    chk_csr("mtval", 12'h343, 32'hDEAD);

    // mtvec low bits are forced to zero.
    csr_op(2'b01, 12'h305, 32'h8003, 1'b0);
    chk_csr("mtvec_wr", 12'h305, 32'h8000);
    trap_seq(4'hB, 32'h200, 32'h0, 32'h8000, 1'b0, 1'b0);
    chk_csr("mcause_b", 12'h342, 32'hB);

    // MIE/MPIE stacking across trap and MRET.
    csr_op(2'b10, 12'h300, 32'h8, 1'b0);
    chk_csr("mstatus_mie", 12'h300, 32'h8);
    trap_seq(4'h3, 32'h204, 32'h0, 32'h8000, 1'b0, 1'b0);
    chk_csr("mstatus_trap", 12'h300, 32'h80);
    bus.mretValid = 1'b1;
    sb_q.push_back(32'h204);
    tick();
    idle_inputs();
    check("mret_latency", {31'd0, bus.redirectValid}, 32'd1);
    wait_drain(3, 1'b0, 32'h0);
    chk_csr("mstatus_mret", 12'h300, 32'h88);

    // Same-cycle CSR write is dropped in favour of the trap.
    trap_seq(4'h4, 32'h208, 32'h1, 32'h8000, 1'b1, 1'b0);
    chk_csr("mscratch_drop", 12'h340, 32'h0);

    // Requests during REDIRECT/DRAIN are ignored.
    trap_seq(4'h5, 32'h300, 32'h2, 32'h8000, 1'b0, 1'b1);
    chk_csr("mepc_noretrig", 12'h341, 32'h300);
    chk_csr("mcause_noretrig", 12'h342, 32'h5);

    // Illegal address, RS/RC semantics, mepc alignment.
    csr_op(2'b01, 12'h7C0, 32'h1234, 1'b1);
    chk_csr("mscratch_illegal", 12'h340, 32'h0);
    csr_op(2'b01, 12'h340, 32'hF0, 1'b0);
    csr_op(2'b11, 12'h340, 32'h0, 1'b0);
    chk_csr("rc_zero", 12'h340, 32'hF0);
    csr_op(2'b11, 12'h340, 32'h30, 1'b0);
    chk_csr("rc_clear", 12'h340, 32'hC0);
    csr_op(2'b10, 12'h340, 32'h1, 1'b0);
    chk_csr("rs_set", 12'h340, 32'hC1);
    csr_op(2'b01, 12'h341, 32'h123, 1'b0);
    chk_csr("mepc_align", 12'h341, 32'h120);

    // Reset while draining.
    bus.trapRequest = 1'b1;
    bus.trapPc = 32'h400;
    sb_q.push_back(32'h8000);
    tick();
    idle_inputs();
    tick();
    check("drain_stall", {31'd0, bus.trapStall}, 32'd1);
    reset = 1'b1;
    tick();
    check("rst_drain_stall", {31'd0, bus.trapStall}, 32'd0);
    check("rst_drain_redirect", {31'd0, bus.redirectValid}, 32'd0);
    reset = 1'b0;
    chk_csr("rst_drain_mtvec", 12'h305, 32'h0);
    chk_csr("rst_drain_mepc", 12'h341, 32'h0);
    chk_csr("rst_drain_mscratch", 12'h340, 32'h0);
    repeat (3) tick();
    check("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
